// File: rtl/mat_unpack_stream.sv
// Serializes one packed I x K float matrix per handshake into a row-major
// element stream with row/column tags, a last marker and a sticky NaN flag.
module mat_unpack_stream #(
  parameter int EXP_WIDTH  = 8,
  parameter int FRAC_WIDTH = 23,
  parameter int I          = 4,
  parameter int K          = 4,
  localparam int W         = 1 + EXP_WIDTH + FRAC_WIDTH,
  localparam int RW        = (I > 1) ? $clog2(I) : 1,
  localparam int CW        = (K > 1) ? $clog2(K) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             mat_valid,
  output logic             mat_ready,
  input  logic [I*K*W-1:0] mat,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W-1:0]     out_data,
  output logic [RW-1:0]    out_row,
  output logic [CW-1:0]    out_col,
  output logic             out_last,
  output logic             nan_seen
);

  localparam int NE = I * K;
  localparam int EW = (NE > 1) ? $clog2(NE) : 1;

  typedef enum logic {IDLE, SEND} state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [I*K*W-1:0]   r_mat;
  logic [RW-1:0]      r_row;
  logic [CW-1:0]      r_col;
  logic               r_nan;
  logic [W-1:0]       w_elem [NE];
  logic [EW-1:0]      w_idx;
  logic               w_last;
  logic               w_acc;
  logic               w_cap;
  logic               w_is_nan;

  for (genvar e = 0; e < NE; e++) begin : g_elem
    assign w_elem[e] = r_mat[e*W +: W];
  end

  assign w_idx    = EW'(r_row) * EW'(K) + EW'(r_col);
  assign w_last   = (r_row == RW'(I - 1)) && (r_col == CW'(K - 1));
  assign w_acc    = out_valid & out_ready;
  assign w_cap    = mat_valid & mat_ready;
  assign w_is_nan = (&out_data[W-2 -: EXP_WIDTH]) & (|out_data[FRAC_WIDTH-1:0]);

  assign out_data = w_elem[w_idx];
  assign out_row  = r_row;
  assign out_col  = r_col;
  assign out_last = (r_state == SEND) & w_last;
  assign nan_seen = r_nan;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // The last accepted beat doubles as a capture window so matrices chain without a bubble.
  always_comb begin
    w_state_nxt = r_state;
    mat_ready   = 1'b0;
    out_valid   = 1'b0;
    case (r_state)
      IDLE: begin
        mat_ready = 1'b1;
        if (mat_valid) w_state_nxt = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        mat_ready = out_ready & w_last;
        if (out_ready && w_last && !mat_valid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mat <= '0;
      r_row <= '0;
      r_col <= '0;
      r_nan <= 1'b0;
    end else begin
      if (w_cap) r_mat <= mat;
      if (w_cap || (w_acc && w_last)) begin
        r_row <= '0;
        r_col <= '0;
      end else if (w_acc) begin
        if (r_col == CW'(K - 1)) begin
          r_col <= '0;
          r_row <= r_row + 1'b1;
        end else begin
          r_col <= r_col + 1'b1;
        end
      end
      // Capture wins: the element accepted in a reload cycle belongs to the old matrix.
      if (w_cap)                 r_nan <= 1'b0;
      else if (w_acc && w_is_nan) r_nan <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mat_unpack_stream.sv
// Directed bench for mat_unpack_stream: a 4x4 instance for ordering, flow
// control and NaN tracking, plus a 1x1 instance for the degenerate shape.
module tb_mat_unpack_stream;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         mat_valid = 1'b0;
  logic         mat_ready;
  logic [511:0] mat = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [31:0]  out_data;
  logic [1:0]   out_row;
  logic [1:0]   out_col;
  logic         out_last;
  logic         nan_seen;

  logic         m1_valid = 1'b0;
  logic         m1_ready;
  logic [31:0]  m1_mat = '0;
  logic         o1_valid;
  logic         o1_ready = 1'b0;
  logic [31:0]  o1_data;
  logic [0:0]   o1_row;
  logic [0:0]   o1_col;
  logic         o1_last;
  logic         o1_nan;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] ea [16];
  logic [31:0] eb [16];

  mat_unpack_stream #(.EXP_WIDTH(8), .FRAC_WIDTH(23), .I(4), .K(4)) dut (
    .clk(clk), .rst_n(rst_n), .mat_valid(mat_valid), .mat_ready(mat_ready), .mat(mat),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_row(out_row),
    .out_col(out_col), .out_last(out_last), .nan_seen(nan_seen)
  );

  mat_unpack_stream #(.EXP_WIDTH(8), .FRAC_WIDTH(23), .I(1), .K(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mat_valid(m1_valid), .mat_ready(m1_ready), .mat(m1_mat),
    .out_valid(o1_valid), .out_ready(o1_ready), .out_data(o1_data), .out_row(o1_row),
    .out_col(o1_col), .out_last(o1_last), .nan_seen(o1_nan)
  );

  always #5 clk = ~clk;

  // IEEE-754 single encoding of a small non-negative integer.
  function automatic logic [31:0] f2b(input int n);
    int e;
    logic [7:0]  ex;
    logic [22:0] fr;
    if (n == 0) return 32'h0;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    ex = 8'(127 + e);
    fr = 23'((n - (1 << e)) << (23 - e));
    return {1'b0, ex, fr};
  endfunction

  function automatic logic [511:0] pack(input bit sel_b);
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = sel_b ? eb[i] : ea[i];
    return r;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; mat_valid = 1'b1; out_ready = 1'b1;
    mat = {16{$urandom}};
    m1_valid = 1'b1; m1_mat = $urandom; o1_ready = 1'b1;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({mat_ready, out_valid, out_row, out_col, out_last, nan_seen} !== 8'b1000_0000) begin
      n_fail++;
      $display("FAIL reset_ctrl: got %b want 10000000",
               {mat_ready, out_valid, out_row, out_col, out_last, nan_seen});
    end
    n_checks++;
    if (out_data !== 32'h0) begin
      n_fail++; $display("FAIL reset_data: got %h want 00000000", out_data);
    end
    n_checks++;
    if ({m1_ready, o1_valid, o1_row, o1_col, o1_last, o1_nan} !== 6'b100000) begin
      n_fail++;
      $display("FAIL reset_1x1: got %b want 100000", {m1_ready, o1_valid, o1_row, o1_col, o1_last, o1_nan});
    end
    mat_valid = 1'b0; m1_valid = 1'b0; rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      n_checks++;
      if ({out_valid, o1_valid} !== 2'b00) begin
        n_fail++; $display("FAIL post_reset_idle[%0d]: got %b want 00", c, {out_valid, o1_valid});
      end
    end
  endtask

  task automatic test_order();
    for (int i = 0; i < 16; i++) ea[i] = f2b(i);
    mat = pack(1'b0); mat_valid = 1'b1; out_ready = 1'b1;
    #1;
    n_checks++;
    if (mat_ready !== 1'b1) begin n_fail++; $display("FAIL order_idle_ready: got %b want 1", mat_ready); end
    @(negedge clk);
    mat_valid = 1'b0;
    for (int b = 0; b < 16; b++) begin
      n_checks++;
      if ({out_valid, out_data, out_row, out_col, out_last} !== {1'b1, f2b(b), 2'(b / 4), 2'(b % 4), b == 15}) begin
        n_fail++;
        $display("FAIL order_beat[%0d]: got v=%b d=%h r=%0d c=%0d l=%b want d=%h", b,
                 out_valid, out_data, out_row, out_col, out_last, f2b(b));
      end
      n_checks++;
      if (mat_ready !== (b == 15)) begin
        n_fail++; $display("FAIL order_mat_ready[%0d]: got %b want %b", b, mat_ready, b == 15);
      end
      @(negedge clk);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL order_done: out_valid got %b want 0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic [3:0] pat = 4'b1001;
    int b = 0;
    for (int i = 0; i < 16; i++) ea[i] = f2b(i + 16);
    mat = pack(1'b0); mat_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    mat_valid = 1'b0;
    for (int cyc = 0; cyc < 100 && b < 16; cyc++) begin
      out_ready = pat[cyc % 4];
      mat = {16{$urandom}};
      n_checks++;
      if ({out_valid, out_data, out_row, out_col, out_last} !== {1'b1, f2b(b + 16), 2'(b / 4), 2'(b % 4), b == 15}) begin
        n_fail++;
        $display("FAIL bp_beat[%0d] cyc %0d: got v=%b d=%h r=%0d c=%0d l=%b want d=%h", b, cyc,
                 out_valid, out_data, out_row, out_col, out_last, f2b(b + 16));
      end
      if (out_ready) b++;
      @(negedge clk);
    end
    n_checks++;
    if (b != 16) begin n_fail++; $display("FAIL bp_count: got %0d beats want 16", b); end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_done: out_valid got %b want 0", out_valid); end
    out_ready = 1'b1;
  endtask

  // Streams ea then eb with mat_valid held, checking data, ready window and NaN flag.
  task automatic run_pair(input string tag, input bit chk_nan, input logic [31:0] nan_mask);
    mat = pack(1'b0); mat_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    mat = pack(1'b1);
    for (int b = 0; b < 32; b++) begin
      logic [31:0] ev;
      ev = (b < 16) ? ea[b] : eb[b - 16];
      n_checks++;
      if ({out_valid, out_data, out_row, out_col, out_last} !==
          {1'b1, ev, 2'((b % 16) / 4), 2'(b % 4), (b % 16) == 15}) begin
        n_fail++;
        $display("FAIL %s_beat[%0d]: got v=%b d=%h r=%0d c=%0d l=%b want d=%h", tag, b,
                 out_valid, out_data, out_row, out_col, out_last, ev);
      end
      n_checks++;
      if (mat_ready !== ((b % 16) == 15)) begin
        n_fail++; $display("FAIL %s_mat_ready[%0d]: got %b want %b", tag, b, mat_ready, (b % 16) == 15);
      end
      if (chk_nan) begin
        n_checks++;
        if (nan_seen !== nan_mask[b]) begin
          n_fail++; $display("FAIL %s_nan_seen[%0d]: got %b want %b", tag, b, nan_seen, nan_mask[b]);
        end
      end
      if (b == 16) mat_valid = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL %s_done: out_valid got %b want 0", tag, out_valid); end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 16; i++) begin ea[i] = f2b(i); eb[i] = f2b(i + 32); end
    run_pair("b2b", 1'b0, 32'h0);
  endtask

  task automatic test_nan();
    for (int i = 0; i < 16; i++) begin ea[i] = f2b(i); eb[i] = f2b(i); end
    ea[6] = 32'h7FC00000; ea[8] = 32'h7F800000; ea[15] = 32'h7F800001;
    eb[1] = 32'h7F800000; eb[15] = 32'hFF800000;
    // Set from beat 7 through 15 of the first matrix, cleared by the back-to-back capture.
    run_pair("nan", 1'b1, 32'h0000_FF80);
  endtask

  task automatic test_degenerate();
    logic [31:0] v [3];
    v[0] = 32'h3F800000; v[1] = 32'h40000000; v[2] = 32'h7FC00000;
    m1_mat = v[0]; m1_valid = 1'b1; o1_ready = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      n_checks++;
      if ({o1_valid, o1_data, o1_row, o1_col, o1_last, m1_ready, o1_nan} !== {1'b1, v[k], 1'b0, 1'b0, 1'b1, 1'b1, 1'b0}) begin
        n_fail++;
        $display("FAIL deg_beat[%0d]: got v=%b d=%h r=%b c=%b l=%b rdy=%b nan=%b want d=%h", k,
                 o1_valid, o1_data, o1_row, o1_col, o1_last, m1_ready, o1_nan, v[k]);
      end
      if (k < 2) m1_mat = v[k + 1];
      else       m1_valid = 1'b0;
      @(negedge clk);
    end
    n_checks++;
    if ({o1_valid, o1_nan} !== 2'b01) begin
      n_fail++; $display("FAIL deg_done: got valid/nan %b want 01", {o1_valid, o1_nan});
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 16; i++) ea[i] = f2b(i);
    ea[2] = 32'h7FC00000;
    mat = pack(1'b0); mat_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    mat_valid = 1'b0;
    for (int b = 0; b < 6; b++) begin
      n_checks++;
      if ({out_valid, out_data, out_row, out_col} !== {1'b1, ea[b], 2'(b / 4), 2'(b % 4)}) begin
        n_fail++;
        $display("FAIL rmid_beat[%0d]: got v=%b d=%h r=%0d c=%0d want d=%h", b,
                 out_valid, out_data, out_row, out_col, ea[b]);
      end
      if (b < 5) @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, mat_ready, out_row, out_col, out_last, nan_seen, out_data} !== {8'b0100_0000, 32'h0}) begin
      n_fail++;
      $display("FAIL rmid_async: got v=%b rdy=%b r=%0d c=%0d l=%b nan=%b d=%h want 0,1,0,0,0,0,0",
               out_valid, mat_ready, out_row, out_col, out_last, nan_seen, out_data);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) ea[i] = f2b(i + 40);
    mat = pack(1'b0); mat_valid = 1'b1;
    @(negedge clk);
    mat_valid = 1'b0;
    for (int b = 0; b < 16; b++) begin
      n_checks++;
      if ({out_valid, out_data, out_row, out_col, out_last} !== {1'b1, f2b(b + 40), 2'(b / 4), 2'(b % 4), b == 15}) begin
        n_fail++;
        $display("FAIL rmid_restart[%0d]: got v=%b d=%h r=%0d c=%0d l=%b want d=%h", b,
                 out_valid, out_data, out_row, out_col, out_last, f2b(b + 40));
      end
      @(negedge clk);
    end
    n_checks++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rmid_done: out_valid got %b want 0", out_valid); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_order();
    test_backpressure();
    test_back_to_back();
    test_nan();
    test_degenerate();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
